// File: rtl/inventory_ctrl.sv
// inventory_ctrl: per-item stock table with add/remove transactions.
// Add clamps at QMAX. Remove is rejected when it would go below zero.
// A registered query port reads any entry on every clock edge.
// Optional build macro: LOW_STOCK_EN adds the low_stock output.
module inventory_ctrl #(
  parameter int CODE_W     = 8,
  parameter int QTY_W      = 8,
  parameter int LOW_THRESH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic              op_mode,
  input  logic [CODE_W-1:0] op_code,
  input  logic [QTY_W-1:0]  op_qty,
  output logic              rsp_valid,
  output logic [QTY_W-1:0]  rsp_qty,
  output logic              rsp_sat,
  output logic              rsp_under,
  output logic [1:0]        debug,
  input  logic [CODE_W-1:0] q_code,
  output logic [QTY_W-1:0]  q_qty
`ifdef LOW_STOCK_EN
  ,output logic             low_stock
`endif
);

  localparam int DEPTH = 2 ** CODE_W;
  localparam logic [QTY_W-1:0]  QMAX     = {QTY_W{1'b1}};
  localparam logic [CODE_W-1:0] LAST_IDX = {CODE_W{1'b1}};

  typedef enum logic [2:0] {
    S_CLEAR = 3'd0,
    S_IDLE  = 3'd1,
    S_RD    = 3'd2,
    S_UPD   = 3'd3,
    S_RSP   = 3'd4
  } state_t;

  // Stock table. It has no reset: CLEAR sweeps it after every reset.
  logic [QTY_W-1:0] r_mem [DEPTH];

  state_t            r_state;
  logic [CODE_W-1:0] r_cnt;
  logic              r_mode;
  logic [CODE_W-1:0] r_code;
  logic [QTY_W-1:0]  r_qty;
  logic [QTY_W-1:0]  r_stock;
  logic              r_op_ready;
  logic              r_rsp_valid;
  logic [QTY_W-1:0]  r_rsp_qty;
  logic              r_rsp_sat;
  logic              r_rsp_under;
  logic [1:0]        r_debug;
  logic [QTY_W-1:0]  r_q_qty;

  logic [QTY_W:0]    w_sum;
  logic              w_sat;
  logic              w_under;
  logic [QTY_W-1:0]  w_new;
  logic              w_we;
  logic [CODE_W-1:0] w_waddr;
  logic [QTY_W-1:0]  w_wdata;

  // Compute the UPD result: the add is evaluated one bit wider so that an overflow can be seen.
  always_comb begin
    w_sum   = {1'b0, r_stock} + {1'b0, r_qty};
    w_sat   = w_sum > {1'b0, QMAX};
    w_under = r_qty > r_stock;
    w_new   = r_stock;
    if (r_mode) begin
      w_new = w_sat ? QMAX : w_sum[QTY_W-1:0];
    end else if (!w_under) begin
      w_new = r_stock - r_qty;
    end
  end

  // Table write port. CLEAR writes zeros. UPD writes the result unless the remove was rejected.
  // Reset blocks every write, so an aborted transaction never reaches the table.
  always_comb begin
    w_we    = 1'b0;
    w_waddr = r_code;
    w_wdata = w_new;
    if (!rst) begin
      if (r_state == S_CLEAR) begin
        w_we    = 1'b1;
        w_waddr = r_cnt;
        w_wdata = '0;
      end else if (r_state == S_UPD && !(!r_mode && w_under)) begin
        w_we = 1'b1;
      end
    end
  end

  // Write the table on the clock edge.
  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[w_waddr] <= w_wdata;
    end
  end

  // Query port. A read of the entry written on the same edge returns the old value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q_qty <= '0;
    end else begin
      r_q_qty <= r_mem[q_code];
    end
  end

  // Control FSM. It sequences the clear sweep and each accepted transaction through RD, UPD and RSP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_CLEAR;
      r_cnt       <= '0;
      r_mode      <= 1'b0;
      r_code      <= '0;
      r_qty       <= '0;
      r_stock     <= '0;
      r_op_ready  <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_qty   <= '0;
      r_rsp_sat   <= 1'b0;
      r_rsp_under <= 1'b0;
      r_debug     <= 2'b00;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        S_CLEAR: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST_IDX) begin
            r_state    <= S_IDLE;
            r_op_ready <= 1'b1;
          end
        end
        S_IDLE: begin
          if (op_valid && r_op_ready) begin
            r_mode     <= op_mode;
            r_code     <= op_code;
            r_qty      <= op_qty;
            r_op_ready <= 1'b0;
            r_state    <= S_RD;
          end
        end
        S_RD: begin
          r_stock <= r_mem[r_code];
          r_state <= S_UPD;
        end
        S_UPD: begin
          r_rsp_qty   <= w_new;
          r_rsp_sat   <= r_mode & w_sat;
          r_rsp_under <= ~r_mode & w_under;
          r_debug     <= {~r_mode, r_mode ? w_sat : w_under};
          r_rsp_valid <= 1'b1;
          r_state     <= S_RSP;
        end
        S_RSP: begin
          r_op_ready <= 1'b1;
          r_state    <= S_IDLE;
        end
        default: begin
          r_state <= S_CLEAR;
          r_cnt   <= '0;
        end
      endcase
    end
  end

`ifdef LOW_STOCK_EN
  localparam logic [QTY_W-1:0] LOW_T = QTY_W'(LOW_THRESH);
  logic r_low_stock;

  // The low-stock flag follows the stock that UPD produces, for both add and remove.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_low_stock <= 1'b0;
    end else if (r_state == S_UPD) begin
      r_low_stock <= (w_new <= LOW_T);
    end
  end

  assign low_stock = r_low_stock;
`endif

  assign op_ready  = r_op_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_qty   = r_rsp_qty;
  assign rsp_sat   = r_rsp_sat;
  assign rsp_under = r_rsp_under;
  assign debug     = r_debug;
  assign q_qty     = r_q_qty;

endmodule

// File: tb/tb_inventory_ctrl.sv
// Testbench for inventory_ctrl. It uses directed and randomized transactions.
// The expected stock comes from a per-code integer model.
module tb_inventory_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       op_valid = 1'b0;
  logic       op_ready;
  logic       op_mode = 1'b0;
  logic [7:0] op_code = '0;
  logic [7:0] op_qty = '0;
  logic       rsp_valid;
  logic [7:0] rsp_qty;
  logic       rsp_sat;
  logic       rsp_under;
  logic [1:0] debug;
  logic [7:0] q_code = '0;
  logic [7:0] q_qty;
`ifdef LOW_STOCK_EN
  logic       low_stock;
`endif

  int errors = 0;
  int checks = 0;
  int model [256];

  inventory_ctrl #(.CODE_W(8), .QTY_W(8), .LOW_THRESH(4)) dut (
    .clk(clk), .rst(rst),
    .op_valid(op_valid), .op_ready(op_ready), .op_mode(op_mode),
    .op_code(op_code), .op_qty(op_qty),
    .rsp_valid(rsp_valid), .rsp_qty(rsp_qty), .rsp_sat(rsp_sat),
    .rsp_under(rsp_under), .debug(debug),
    .q_code(q_code), .q_qty(q_qty)
`ifdef LOW_STOCK_EN
    , .low_stock(low_stock)
`endif
  );

  always #5 clk = ~clk;

  // Wait for op_ready and check that it takes exactly the expected number of cycles.
  task automatic wait_ready(input int expect_cycles, input string tag);
    int n = 0;
    while (op_ready !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (op_ready !== 1'b1 || (expect_cycles >= 0 && n != expect_cycles)) begin
      errors++;
      $display("FAIL %s_clear_len got ready=%b after %0d cycles, want 1 after %0d", tag, op_ready, n, expect_cycles);
    end
  endtask

  task automatic check_query(input int code);
    q_code = 8'(code);
    @(negedge clk);
    checks++;
    if (q_qty !== 8'(model[code])) begin
      errors++;
      $display("FAIL query code=%02h got %0d want %0d", code, q_qty, model[code]);
    end else
      $display("query code=%02h qty=%0d", code, q_qty);
  endtask

  // Run one transaction and check the response timing and fields against the model.
  // If junk is set, op_valid stays high with random fields through RD, UPD and RSP.
  task automatic do_op(input bit mode, input int code, input int qty, input bit junk);
    int old_v, new_v;
    bit e_sat, e_under;
    logic [1:0] e_dbg;
    wait_ready(-1, "op");
    if (op_ready !== 1'b1) return;
    old_v = model[code];
    e_sat = 0; e_under = 0;
    if (mode) begin
      new_v = old_v + qty;
      if (new_v > 255) begin new_v = 255; e_sat = 1; end
      e_dbg = e_sat ? 2'b01 : 2'b00;
    end else begin
      if (qty > old_v) begin new_v = old_v; e_under = 1; end
      else new_v = old_v - qty;
      e_dbg = e_under ? 2'b11 : 2'b10;
    end
    op_valid = 1'b1; op_mode = mode; op_code = 8'(code); op_qty = 8'(qty); q_code = 8'(code);
    @(negedge clk);  // after the accept edge
    checks++;
    if (op_ready !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL accept_state got ready=%b rsp_valid=%b want 0 0", op_ready, rsp_valid);
    end
    if (junk) begin op_mode = 1'($urandom); op_code = 8'($urandom); op_qty = 8'($urandom); end
    else op_valid = 1'b0;
    @(negedge clk);  // after the RD edge
    checks++;
    if (rsp_valid !== 1'b0 || q_qty !== 8'(old_v)) begin
      errors++;
      $display("FAIL rd_cycle got rsp_valid=%b q_qty=%0d want 0 %0d", rsp_valid, q_qty, old_v);
    end
    if (junk) begin op_mode = 1'($urandom); op_code = 8'($urandom); op_qty = 8'($urandom); end
    @(negedge clk);  // after the UPD edge: the response cycle
    checks++;
    if (rsp_valid !== 1'b1 || rsp_qty !== 8'(new_v) || rsp_sat !== e_sat ||
        rsp_under !== e_under || debug !== e_dbg || q_qty !== 8'(old_v)) begin
      errors++;
      $display("FAIL rsp code=%02h got v=%b qty=%0d sat=%b under=%b dbg=%b q=%0d want 1 %0d %b %b %b %0d",
               code, rsp_valid, rsp_qty, rsp_sat, rsp_under, debug, q_qty,
               new_v, e_sat, e_under, e_dbg, old_v);
    end else
      $display("op mode=%0d code=%02h qty=%0d -> stock=%0d sat=%0d under=%0d dbg=%b",
               mode, code, qty, rsp_qty, rsp_sat, rsp_under, debug);
`ifdef LOW_STOCK_EN
    checks++;
    if (low_stock !== (new_v <= 4)) begin
      errors++;
      $display("FAIL low_stock got %b want %b", low_stock, (new_v <= 4));
    end
`endif
    model[code] = new_v;
    if (junk) begin op_code = 8'($urandom); op_qty = 8'($urandom); end
    @(negedge clk);  // after the RSP edge
    op_valid = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || op_ready !== 1'b1 || rsp_qty !== 8'(new_v) ||
        debug !== e_dbg || q_qty !== 8'(new_v)) begin
      errors++;
      $display("FAIL post_rsp got v=%b ready=%b qty=%0d dbg=%b q=%0d want 0 1 %0d %b %0d",
               rsp_valid, op_ready, rsp_qty, debug, q_qty, new_v, e_dbg, new_v);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if (op_ready !== 1'b0 || rsp_valid !== 1'b0 || rsp_qty !== 8'd0 || rsp_sat !== 1'b0 ||
        rsp_under !== 1'b0 || debug !== 2'b00 || q_qty !== 8'd0) begin
      errors++;
      $display("FAIL %s_outputs got ready=%b v=%b qty=%0d sat=%b under=%b dbg=%b q=%0d want all 0",
               tag, op_ready, rsp_valid, rsp_qty, rsp_sat, rsp_under, debug, q_qty);
    end
`ifdef LOW_STOCK_EN
    checks++;
    if (low_stock !== 1'b0) begin
      errors++;
      $display("FAIL %s_low_stock got %b want 0", tag, low_stock);
    end
`endif
  endtask

  task automatic test_reset();
    for (int i = 0; i < 256; i++) model[i] = 0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    wait_ready(256, "reset");
    check_query(8'h00);
    check_query(8'h7F);
    check_query(8'hFF);
  endtask

  task automatic test_directed();
    do_op(1'b1, 8'h12, 100, 1'b0);
    do_op(1'b1, 8'h12, 50, 1'b0);
    do_op(1'b1, 8'h12, 200, 1'b0);
    check_query(8'h12);
    do_op(1'b0, 8'h12, 255, 1'b0);
    do_op(1'b0, 8'h12, 1, 1'b0);
    check_query(8'h12);
    do_op(1'b1, 8'h12, 0, 1'b0);
    do_op(1'b0, 8'h12, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    do_op(1'b1, 8'h40, 30, 1'b1);
    do_op(1'b0, 8'h40, 10, 1'b1);
    do_op(1'b1, 8'h41, 7, 1'b1);
    check_query(8'h40);
    check_query(8'h41);
  endtask

  task automatic test_random();
    int code, qty;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 4))
        0: code = 8'h12;
        1: code = 8'h34;
        2: code = 8'hAB;
        3: code = 8'hFF;
        default: code = $urandom_range(0, 255);
      endcase
      qty = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 90);
      do_op(1'($urandom), code, qty, 1'($urandom));
    end
    check_query(8'h34);
    check_query(8'hAB);
  endtask

  // Abort a transaction with a reset during UPD, then check that the table is fully cleared.
  task automatic test_reset_mid();
    do_op(1'b1, 8'h55, 90, 1'b0);
    wait_ready(-1, "mid");
    op_valid = 1'b1; op_mode = 1'b1; op_code = 8'h55; op_qty = 8'd20;
    @(negedge clk);
    op_valid = 1'b0;
    @(negedge clk);  // the FSM is now in UPD
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 256; i++) model[i] = 0;
    wait_ready(256, "midrst");
    check_query(8'h55);
    check_query(8'h12);
    check_query(8'hFF);
  endtask

`ifdef LOW_STOCK_EN
  task automatic test_low_stock();
    do_op(1'b1, 8'h60, 5, 1'b0);
    do_op(1'b0, 8'h60, 1, 1'b0);
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
`ifdef LOW_STOCK_EN
    test_low_stock();
`endif
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/inventory_ctrl.md
# inventory_ctrl

Parametrised, clocked stock-keeping controller: holds one quantity per item code in an internal table and applies add/remove transactions with saturation and underflow protection. It replaces the edge-triggered save/submit core. Operations arrive through a valid/ready handshake and complete with a one-cycle response pulse. A registered query port lets the display path read any item's stock at any time.

## Interface
Parameters:
- CODE_W, 8, item code width; table depth is 2**CODE_W entries
- QTY_W, 8, quantity width; max stock QMAX = 2**QTY_W-1
- LOW_THRESH, 4, low-stock threshold; used only when LOW_STOCK_EN is defined

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- op_valid  in  1  transaction request
- op_ready  out  1  controller can accept a transaction
- op_mode  in  1  1 = add, 0 = remove
- op_code  in  CODE_W  item code
- op_qty  in  QTY_W  quantity to add/remove
- rsp_valid  out  1  one-cycle completion pulse
- rsp_qty  out  QTY_W  stock of the item after the transaction
- rsp_sat  out  1  add was clamped to QMAX
- rsp_under  out  1  remove rejected, op_qty > stock
- debug  out  2  last accepted op: 00 add ok, 01 add saturated, 10 remove ok, 11 remove rejected
- q_code  in  CODE_W  query address
- q_qty  out  QTY_W  registered stock of q_code
- low_stock  out  1  (LOW_STOCK_EN only) rsp item stock ≤ LOW_THRESH

## Operation
- States: CLEAR, IDLE, RD, UPD, RSP.
- CLEAR: entered on reset; sweeps a CODE_W-bit counter from 0 to 2**CODE_W-1, writing 0 to one entry per cycle; op_ready=0; goes to IDLE after writing the last entry.
- IDLE: op_ready=1; on op_valid&&op_ready, latch mode/code/qty and go to RD. op_* are ignored in all other states.
- RD: latch stock = table[code] into working register; go to UPD.
- UPD, add: sum is computed at QTY_W+1 bits; if sum > QMAX, write QMAX and set sat; otherwise write sum.
- UPD, remove: if qty > stock, leave the table unchanged and set under; otherwise write stock-qty. Removing exactly the full stock gives 0, which is legal.
- UPD also loads rsp_qty, rsp_sat, rsp_under and debug, then goes to RSP.
- RSP: rsp_valid=1 for this single cycle, then go to IDLE. There is no response backpressure.
- add of 0 and remove of 0 are legal no-ops that still produce a response.
- Query port: q_qty <= table[q_code] on every edge, including during CLEAR, where it may read a not-yet-cleared entry. If a query reads the entry being written in the same edge, it returns the old value (read-before-write).

## Timing
- Reset values: op_ready=0, rsp_valid=0, rsp_qty=0, rsp_sat=0, rsp_under=0, debug=00, q_qty=0, low_stock=0, state=CLEAR, clear counter=0.
- After rst deasserts: 2**CODE_W cycles in CLEAR, then op_ready=1.
- Accept at edge N; rsp_valid is high during the cycle after edge N+2; the table entry is updated at edge N+2; op_ready returns at edge N+3.
- Throughput: one transaction per 4 cycles.
- rsp_qty, rsp_sat, rsp_under and debug hold their values until the next UPD.
- Query latency: 1 cycle.
- rst asserted mid-transaction: the transaction is aborted, no further write is performed, and all outputs return to reset values immediately. The table is fully re-cleared by CLEAR.

## Configuration
- LOW_STOCK_EN defined: a low_stock port exists. At UPD it is registered as (resulting stock ≤ LOW_THRESH) for both add and remove. It holds that value until the next UPD and resets to 0.
- LOW_STOCK_EN undefined: the port and its logic are absent; all other behaviour is identical.

## Test plan
- Reset, wait: op_ready=0 for 256 cycles (CODE_W=8), then 1; query of codes 0, 0x7F and 0xFF all return 0.
- Add code 0x12 qty 100, then add qty 50: rsp_qty=100, then 150; rsp_sat=0; debug=00; rsp_valid pulses exactly 1 cycle, 2 cycles after accept.
- With code 0x12 at 150, add 200: rsp_qty=255, rsp_sat=1, debug=01; query 0x12 returns 255.
- With code 0x12 at 255, remove 256-1=255: rsp_qty=0, debug=10. Then remove 1: rsp_under=1, rsp_qty=0, debug=11, table unchanged.
- Hold op_valid high with changing op_code during RD/UPD/RSP: only the IDLE-accepted request executes; pulse rst during UPD: no write occurs, CLEAR restarts, and all entries read 0 afterwards.
- LOW_STOCK_EN with LOW_THRESH=4: add 5 → low_stock=0; remove 1 → stock 4, low_stock=1. Without the macro, the build contains no low_stock port.
